// File: rtl/bayer_pkg.sv
// rtl/bayer_pkg.sv - CFA phase codes and frame controller state encoding
package bayer_pkg;

    typedef enum logic [1:0] {
        CFA_BGGR = 2'b00,
        CFA_GBRG = 2'b01,
        CFA_GRBG = 2'b10,
        CFA_RGGB = 2'b11
    } cfa_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MEASURE = 2'b01,
        ST_CHECK   = 2'b10,
        ST_LOCKED  = 2'b11
    } ctrl_state_e;

endpackage

// File: rtl/frame_geom_meas.sv
// rtl/frame_geom_meas.sv - per-frame line length / line count measurement with end-of-frame summary
module frame_geom_meas #(
    parameter int CNT_W    = 16,
    parameter int MAX_HRES = 2048
) (
    input  logic             pix_clk,
    input  logic             rst_n,
    input  logic             vs_i,
    input  logic             de_i,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] frame_h_o,
    output logic [CNT_W-1:0] frame_v_o,
    output logic             frame_valid_o,
    output logic             frame_geom_err_o
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] HRES_MAX = CNT_W'(MAX_HRES);

    logic             r_vs_d, r_vs_dd, r_de_d, r_de_dd;
    logic [CNT_W-1:0] r_hcnt, r_line_cnt, r_line_len;
    logic             r_frame_bad;

    logic             w_vs_rise, w_de_rise, w_de_fall, w_first_line, w_len_mismatch, w_frame_bad;
    logic [CNT_W-1:0] w_hcnt_inc, w_line_cnt_inc;

    assign w_vs_rise      = r_vs_d & ~r_vs_dd;
    assign w_de_rise      = r_de_d & ~r_de_dd;
    assign w_de_fall      = ~r_de_d & r_de_dd;
    assign w_first_line   = (r_line_cnt == '0);
    assign w_hcnt_inc     = (r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + 1'b1;
    assign w_line_cnt_inc = (r_line_cnt == CNT_MAX) ? r_line_cnt : r_line_cnt + 1'b1;
    assign w_len_mismatch = w_de_fall && !w_first_line && (r_hcnt != r_line_len);

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d      <= 1'b0;
            r_vs_dd     <= 1'b0;
            r_de_d      <= 1'b0;
            r_de_dd     <= 1'b0;
            r_hcnt      <= '0;
            r_line_cnt  <= '0;
            r_line_len  <= '0;
            r_frame_bad <= 1'b0;
        end else begin
            r_vs_d  <= vs_i;
            r_vs_dd <= r_vs_d;
            r_de_d  <= de_i;
            r_de_dd <= r_de_d;
            if (w_vs_rise) begin
                // a line starting on the boundary cycle still counts its first pixel
                r_hcnt      <= w_de_rise ? CNT_W'(1) : '0;
                r_line_cnt  <= '0;
                r_line_len  <= '0;
                r_frame_bad <= 1'b0;
            end else begin
                if (w_de_rise) begin
                    r_hcnt <= CNT_W'(1);
                end else if (r_de_d) begin
                    r_hcnt <= w_hcnt_inc;
                end
                if (w_de_fall) begin
                    if (w_first_line) begin
                        r_line_len <= r_hcnt;
                    end
                    r_line_cnt <= w_line_cnt_inc;
                end
                if (w_len_mismatch) begin
                    r_frame_bad <= 1'b1;
                end
            end
        end
    end

    // A line ending on the boundary cycle is folded into the frame being closed
    assign w_frame_bad      = r_frame_bad | w_len_mismatch;
    assign frame_done_o     = w_vs_rise;
    assign frame_v_o        = w_de_fall ? w_line_cnt_inc : r_line_cnt;
    assign frame_h_o        = (w_de_fall && w_first_line) ? r_hcnt : r_line_len;
    assign frame_geom_err_o = (frame_h_o == '0) || frame_h_o[0] || (frame_h_o > HRES_MAX);
    assign frame_valid_o    = !w_frame_bad && (frame_v_o != '0) && !frame_geom_err_o;

endmodule

// File: rtl/bayer_frame_ctrl.sv
// rtl/bayer_frame_ctrl.sv - geometry lock FSM publishing line length, CFA phase and demosaic enable
module bayer_frame_ctrl
    import bayer_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MAX_HRES    = 2048,
    parameter int LOCK_FRAMES = 3
) (
    input  logic             pix_clk,
    input  logic             rst_n,
    input  logic             vs_i,
    input  logic             de_i,
    input  logic             cfg_en,
    input  logic [1:0]       cfg_pattern,
    output logic [CNT_W-1:0] hres_o,
    output logic [CNT_W-1:0] vres_o,
    output logic [1:0]       pattern_o,
    output logic             dm_en_o,
    output logic             lock_o,
    output logic             err_o
);
    localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_FRAMES);

    logic             w_frame_done, w_frame_valid, w_frame_geom_err;
    logic [CNT_W-1:0] w_frame_h, w_frame_v;

    ctrl_state_e      r_state, w_next_state;
    logic [CNT_W-1:0] r_cand_h, r_cand_v, r_match, r_hres, r_vres;
    cfa_e             r_pattern;
    logic             r_dm_en, r_lock, r_err;
    logic             w_same, w_match_full, w_capture, w_match_inc, w_enter_lock;

    frame_geom_meas #(
        .CNT_W   (CNT_W),
        .MAX_HRES(MAX_HRES)
    ) u_meas (
        .pix_clk         (pix_clk),
        .rst_n           (rst_n),
        .vs_i            (vs_i),
        .de_i            (de_i),
        .frame_done_o    (w_frame_done),
        .frame_h_o       (w_frame_h),
        .frame_v_o       (w_frame_v),
        .frame_valid_o   (w_frame_valid),
        .frame_geom_err_o(w_frame_geom_err)
    );

    assign w_same       = (w_frame_h == r_cand_h) && (w_frame_v == r_cand_v);
    assign w_match_full = (r_match + 1'b1) >= LOCK_N;

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_frame_done) begin
            if (!cfg_en) begin
                w_next_state = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE:    w_next_state = ST_MEASURE;
                    ST_MEASURE: begin
                        if (w_frame_valid) begin
                            w_next_state = (LOCK_FRAMES == 1) ? ST_LOCKED : ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (!w_frame_valid) begin
                            w_next_state = ST_MEASURE;
                        end else if (w_same && w_match_full) begin
                            w_next_state = ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        if (!(w_frame_valid && w_same)) begin
                            w_next_state = ST_MEASURE;
                        end
                    end
                    default:    w_next_state = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_capture   = 1'b0;
        w_match_inc = 1'b0;
        if (w_frame_done && cfg_en) begin
            case (r_state)
                ST_MEASURE: w_capture = w_frame_valid;
                ST_CHECK: begin
                    w_capture   = w_frame_valid && !w_same;
                    w_match_inc = w_frame_valid && w_same;
                end
                default: ;
            endcase
        end
        w_enter_lock = (w_next_state == ST_LOCKED) && (r_state != ST_LOCKED);
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand_h  <= '0;
            r_cand_v  <= '0;
            r_match   <= '0;
            r_hres    <= '0;
            r_vres    <= '0;
            r_pattern <= CFA_BGGR;
            r_dm_en   <= 1'b0;
            r_lock    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cand_h <= w_frame_h;
                r_cand_v <= w_frame_v;
                r_match  <= CNT_W'(1);
            end else if (w_match_inc) begin
                r_match <= r_match + 1'b1;
            end
            // the closing frame equals the candidate whenever lock is entered
            if (w_enter_lock) begin
                r_hres <= w_frame_h;
                r_vres <= w_frame_v;
            end
            if (w_frame_done) begin
                r_pattern <= cfa_e'(cfg_pattern);
                r_lock    <= (w_next_state == ST_LOCKED);
                r_dm_en   <= (w_next_state == ST_LOCKED) && cfg_en;
            end
            if (!cfg_en) begin
                r_err <= 1'b0;
            end else if (w_frame_done && (r_state != ST_IDLE) && w_frame_geom_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign hres_o    = r_hres;
    assign vres_o    = r_vres;
    assign pattern_o = r_pattern;
    assign dm_en_o   = r_dm_en;
    assign lock_o    = r_lock;
    assign err_o     = r_err;

endmodule

// File: tb/tb_bayer_frame_ctrl.sv
// tb/tb_bayer_frame_ctrl.sv - frame-level stimulus against a streak-counting reference model
module tb_bayer_frame_ctrl;
    localparam int CNT_W       = 16;
    localparam int MAX_HRES    = 2048;
    localparam int LOCK_FRAMES = 3;

    logic             pix_clk = 1'b0;
    logic             rst_n, vs_i, de_i, cfg_en;
    logic [1:0]       cfg_pattern;
    logic [CNT_W-1:0] hres_o, vres_o;
    logic [1:0]       pattern_o;
    logic             dm_en_o, lock_o, err_o;

    int total = 0;
    int bad   = 0;

    // reference model: lines of the open frame, and a run of identical valid frames
    int               cur_lines[$];
    bit               m_en;
    int               m_run, m_h, m_v;
    logic             e_lock, e_dm, e_err;
    logic [1:0]       e_pat;
    logic [CNT_W-1:0] e_hres, e_vres;

    bayer_frame_ctrl #(
        .CNT_W      (CNT_W),
        .MAX_HRES   (MAX_HRES),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .pix_clk    (pix_clk),
        .rst_n      (rst_n),
        .vs_i       (vs_i),
        .de_i       (de_i),
        .cfg_en     (cfg_en),
        .cfg_pattern(cfg_pattern),
        .hres_o     (hres_o),
        .vres_o     (vres_o),
        .pattern_o  (pattern_o),
        .dm_en_o    (dm_en_o),
        .lock_o     (lock_o),
        .err_o      (err_o)
    );

    always #5 pix_clk = ~pix_clk;

    function automatic logic [36:0] obs_vec();
        return {lock_o, dm_en_o, err_o, pattern_o, hres_o, vres_o};
    endfunction

    function automatic logic [36:0] exp_vec();
        return {e_lock, e_dm, e_err, e_pat, e_hres, e_vres};
    endfunction

    task automatic model_reset();
        m_en = 1'b0; m_run = 0; m_h = 0; m_v = 0;
        e_lock = 1'b0; e_dm = 1'b0; e_err = 1'b0; e_pat = 2'b00; e_hres = '0; e_vres = '0;
        cur_lines.delete();
    endtask

    task automatic model_boundary();
        int  h, v;
        bit  fbad, gerr, valid;
        v    = cur_lines.size();
        h    = (v > 0) ? cur_lines[0] : 0;
        fbad = 1'b0;
        foreach (cur_lines[i]) if (cur_lines[i] != h) fbad = 1'b1;
        gerr  = (h == 0) || (h % 2 == 1) || (h > MAX_HRES);
        valid = !fbad && (v > 0) && !gerr;
        e_pat = cfg_pattern;
        if (!cfg_en) begin
            m_en = 1'b0; m_run = 0; e_lock = 1'b0; e_err = 1'b0;
        end else if (!m_en) begin
            m_en = 1'b1;
        end else begin
            if (gerr) e_err = 1'b1;
            if (e_lock) begin
                if (!(valid && h == m_h && v == m_v)) begin
                    e_lock = 1'b0; m_run = 0;
                end
            end else if (!valid) begin
                m_run = 0;
            end else if (m_run > 0 && h == m_h && v == m_v) begin
                m_run++;
            end else begin
                m_run = 1; m_h = h; m_v = v;
            end
            if (!e_lock && m_run >= LOCK_FRAMES) begin
                e_lock = 1'b1; e_hres = CNT_W'(m_h); e_vres = CNT_W'(m_v);
            end
        end
        e_dm = e_lock && cfg_en;
        cur_lines.delete();
    endtask

    task automatic send_line(input int len);
        cur_lines.push_back(len);
        de_i = 1'b1;
        repeat (len) @(negedge pix_clk);
        de_i = 1'b0;
        repeat (3) @(negedge pix_clk);
    endtask

    task automatic send_line_open(input int len);
        cur_lines.push_back(len);
        de_i = 1'b1;
        repeat (len) @(negedge pix_clk);
    endtask

    task automatic send_frame(input int lines, input int w);
        for (int i = 0; i < lines; i++) send_line(w);
    endtask

    task automatic boundary_start();
        vs_i = 1'b1;
        de_i = 1'b0;
        @(negedge pix_clk);
    endtask

    task automatic boundary_end();
        @(negedge pix_clk);
        model_boundary();
        vs_i = 1'b0;
        repeat (2) @(negedge pix_clk);
    endtask

    task automatic boundary();
        boundary_start();
        boundary_end();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vs_i = 1'b0; de_i = 1'b0; cfg_en = 1'b0; cfg_pattern = 2'b00;
        model_reset();
        repeat (3) @(negedge pix_clk);
        total++;
        if (obs_vec() !== 37'd0) begin
            bad++; $display("FAIL reset: got=%h exp=0", obs_vec());
        end
        rst_n = 1'b1;
        @(negedge pix_clk);
    endtask

    task automatic test_basic_lock();
        cfg_en = 1'b1; cfg_pattern = 2'b10;
        boundary();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL basic_b1: got=%h exp=%h", obs_vec(), exp_vec());
        end
        for (int f = 1; f <= 5; f++) begin
            send_frame(4, 8);
            boundary();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL basic_f%0d: got=%h exp=%h", f, obs_vec(), exp_vec());
            end
            total++;
            if (lock_o !== (f >= 3) || dm_en_o !== (f >= 3)) begin
                bad++; $display("FAIL basic_lock_f%0d: lock=%b dm=%b exp=%b", f, lock_o, dm_en_o, f >= 3);
            end
        end
        total++;
        if (hres_o !== 16'd8 || vres_o !== 16'd4 || pattern_o !== 2'b10 || err_o !== 1'b0) begin
            bad++; $display("FAIL basic_geom: h=%0d v=%0d pat=%0d err=%b exp 8 4 2 0", hres_o, vres_o, pattern_o, err_o);
        end
    endtask

    task automatic test_lost_lock();
        send_line(8); send_line(6); send_line(8); send_line(8);
        boundary();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL lost_model: got=%h exp=%h", obs_vec(), exp_vec());
        end
        total++;
        if (lock_o !== 1'b0 || dm_en_o !== 1'b0 || hres_o !== 16'd8) begin
            bad++; $display("FAIL lost_drop: lock=%b dm=%b h=%0d exp 0 0 8", lock_o, dm_en_o, hres_o);
        end
        for (int f = 1; f <= 3; f++) begin
            send_frame(4, 8);
            boundary();
            total++;
            if (obs_vec() !== exp_vec() || lock_o !== (f == 3)) begin
                bad++; $display("FAIL relock_f%0d: got=%h exp=%h", f, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_illegal();
        for (int f = 0; f < 2; f++) begin
            send_frame(4, 7);
            boundary();
            total++;
            if (obs_vec() !== exp_vec() || err_o !== 1'b1 || lock_o !== 1'b0) begin
                bad++; $display("FAIL odd_f%0d: got=%h exp=%h", f, obs_vec(), exp_vec());
            end
        end
        cfg_en = 1'b0;
        repeat (2) @(negedge pix_clk);
        total++;
        if (err_o !== 1'b0) begin
            bad++; $display("FAIL err_clear: err=%b exp=0", err_o);
        end
        e_err  = 1'b0;
        cfg_en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            send_frame(4, 2050);
            boundary();
            total++;
            if (obs_vec() !== exp_vec() || err_o !== 1'b1 || lock_o !== 1'b0) begin
                bad++; $display("FAIL wide_f%0d: got=%h exp=%h", f, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_mid_frame_cfg();
        for (int f = 1; f <= 3; f++) begin
            send_frame(4, 8);
            boundary();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL mid_pre_f%0d: got=%h exp=%h", f, obs_vec(), exp_vec());
            end
        end
        send_frame(2, 8);
        cfg_en = 1'b0; cfg_pattern = 2'b01;
        send_frame(2, 8);
        boundary_start();
        total++;
        if (dm_en_o !== 1'b1 || pattern_o !== 2'b10 || lock_o !== 1'b1) begin
            bad++; $display("FAIL mid_hold: dm=%b pat=%0d lock=%b exp 1 2 1", dm_en_o, pattern_o, lock_o);
        end
        boundary_end();
        total++;
        if (obs_vec() !== exp_vec() || dm_en_o !== 1'b0 || pattern_o !== 2'b01) begin
            bad++; $display("FAIL mid_apply: got=%h exp=%h", obs_vec(), exp_vec());
        end
        cfg_en = 1'b1;
    endtask

    task automatic test_simultaneous();
        boundary();
        for (int f = 1; f <= 3; f++) begin
            send_frame(3, 10);
            send_line_open(10);
            boundary();
            total++;
            if (obs_vec() !== exp_vec() || lock_o !== (f == 3)) begin
                bad++; $display("FAIL simul_f%0d: got=%h exp=%h", f, obs_vec(), exp_vec());
            end
        end
        total++;
        if (vres_o !== 16'd4 || hres_o !== 16'd10) begin
            bad++; $display("FAIL simul_geom: h=%0d v=%0d exp 10 4", hres_o, vres_o);
        end
    endtask

    task automatic test_reset_mid();
        send_frame(2, 10);
        rst_n = 1'b0;
        #1;
        total++;
        if (obs_vec() !== 37'd0) begin
            bad++; $display("FAIL reset_mid: got=%h exp=0", obs_vec());
        end
        model_reset();
        @(negedge pix_clk);
        rst_n = 1'b1;
        send_frame(2, 10);
        boundary();
        for (int b = 2; b <= 4; b++) begin
            send_frame(4, 10);
            boundary();
            total++;
            if (obs_vec() !== exp_vec() || lock_o !== (b == 4)) begin
                bad++; $display("FAIL relock_rst_b%0d: got=%h exp=%h", b, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int rw, rl, w;
        rw = 12; rl = 3;
        for (int f = 0; f < 30; f++) begin
            cfg_en      = ($urandom_range(0, 7) != 0);
            cfg_pattern = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                rw = 2 * $urandom_range(1, 20) + (($urandom_range(0, 7) == 0) ? 1 : 0);
                rl = $urandom_range(1, 5);
            end
            for (int l = 0; l < rl; l++) begin
                w = ($urandom_range(0, 11) == 0) ? rw + 2 : rw;
                if (l == rl - 1 && $urandom_range(0, 1) == 1) send_line_open(w);
                else send_line(w);
            end
            boundary();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL random_f%0d: got=%h exp=%h", f, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_lock();
        test_lost_lock();
        test_illegal();
        test_mid_frame_cfg();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
